// File: rtl/mmips_netdev.sv
// Memory-mapped packet network device on the CPU data-memory device window.
// It sends staged data words as link flits and buffers received flits in a first-word-fall-through (FWFT) RX FIFO.
//
// state | meaning
// IDLE  | no flit in flight; dev_rdyw=1, a send command is accepted
// SEND  | flit presented on the link (tx_valid=1) until tx_ready
module mmips_netdev #(
  parameter int DEST_W   = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       dev_din,
  input  logic              dev_wdata,
  input  logic              dev_waddr,
  input  logic              dev_w,
  input  logic              dev_send_eop,
  input  logic              dev_r,
  output logic [31:0]       dev_dout,
  output logic              dev_rdyr,
  output logic              dev_rcv_eop,
  output logic              dev_rdyw,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [31:0]       tx_data,
  output logic [DEST_W-1:0] tx_dest,
  output logic              tx_eop,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [31:0]       rx_data,
  input  logic              rx_eop
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  tx_state_e         state_q, state_d;
  logic [31:0]       stage_q, stage_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic [DEST_W-1:0] tx_dest_q, tx_dest_d;
  logic              tx_eop_q, tx_eop_d;
  logic              send_cmd;

  // dev_w is only legal inside the control-word strobe.
  assign send_cmd = dev_w & dev_waddr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      tx_data_q <= '0;
      tx_dest_q <= '0;
      tx_eop_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      tx_data_q <= tx_data_d;
      tx_dest_q <= tx_dest_d;
      tx_eop_q  <= tx_eop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    tx_data_d = tx_data_q;
    tx_dest_d = tx_dest_q;
    tx_eop_d  = tx_eop_q;
    if (dev_wdata) begin
      stage_d = dev_din;
    end
    if (state_q == IDLE) begin
      if (send_cmd) begin
        tx_data_d = dev_wdata ? dev_din : stage_q;
        tx_dest_d = dev_din[DEST_W-1:0];
        tx_eop_d  = dev_send_eop;
        state_d   = SEND;
      end
    end else begin
      if (tx_ready) begin
        state_d = IDLE;
      end
    end
  end

  assign tx_valid = (state_q == SEND);
  assign dev_rdyw = (state_q == IDLE);
  assign tx_data  = tx_data_q;
  assign tx_dest  = tx_dest_q;
  assign tx_eop   = tx_eop_q;

  // Each entry holds {eop, data}. The pointers carry an extra wrap bit so that full and empty can be told apart.
  logic [32:0] mem_q [RX_DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty, fifo_full, do_push, do_pop;
  logic [32:0] head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign do_push    = rx_valid & ~fifo_full;
  assign do_pop     = dev_r & ~fifo_empty;
  assign wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < RX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= {rx_eop, rx_data};
      end
    end
  end

  // The master samples dev_dout on the pop edge, so the head is read combinationally.
  assign head        = mem_q[rd_ptr_q[PW-1:0]];
  assign rx_ready    = ~fifo_full;
  assign dev_rdyr    = ~fifo_empty;
  assign dev_dout    = fifo_empty ? 32'h0 : head[31:0];
  assign dev_rcv_eop = fifo_empty ? 1'b0  : head[32];

endmodule
